// File: rtl/riscv_core_dcache_wb_nway.sv
// riscv_core_dcache_wb_nway: N-way write-back/write-allocate L1 data cache, single-cycle hit path.
// Define DCACHE_PERF_CNT_EN to add hit/miss/write-back counters.
module riscv_core_dcache_wb_nway #(
   parameter int ADDR_WIDTH      = 64,
   parameter int CORE_DATA_WIDTH = 64,
   parameter int LINE_WIDTH      = 256,
   parameter int NUM_SETS        = 128,
   parameter int NUM_WAYS        = 2
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic [ADDR_WIDTH-1:0]      i_addr_from_core,
   input  logic [CORE_DATA_WIDTH-1:0] i_data_from_core,
   input  logic                       i_read,
   input  logic                       i_write,
   input  logic [1:0]                 i_size,
   output logic                       o_stall,
   output logic [CORE_DATA_WIDTH-1:0] o_data_to_core,
   output logic                       o_load_fault,
   output logic                       o_store_fault,
   output logic                       o_mem_read_req,
   output logic [ADDR_WIDTH-1:0]      o_mem_read_address,
   input  logic                       i_mem_read_done,
   input  logic [LINE_WIDTH-1:0]      i_block_from_axi,
   output logic                       o_mem_write_valid,
   output logic [ADDR_WIDTH-1:0]      o_mem_write_address,
   output logic [LINE_WIDTH-1:0]      o_mem_write_block,
`ifdef DCACHE_PERF_CNT_EN
   output logic [31:0]                o_hit_count,
   output logic [31:0]                o_miss_count,
   output logic [31:0]                o_wb_count,
`endif
   input  logic                       i_mem_write_done
);
   localparam int OFFSET_W = $clog2(LINE_WIDTH/8);
   localparam int INDEX_W  = $clog2(NUM_SETS);
   localparam int TAG_W    = ADDR_WIDTH - INDEX_W - OFFSET_W;
   localparam int WAY_W    = NUM_WAYS > 1 ? $clog2(NUM_WAYS) : 1;
   localparam int NB       = LINE_WIDTH/8;
   localparam logic [1:0] S_IDLE = 2'd0, S_WB = 2'd1, S_REFILL = 2'd2;

   logic [LINE_WIDTH-1:0] data_q [NUM_WAYS][NUM_SETS];
   logic [TAG_W-1:0]      tag_q  [NUM_WAYS][NUM_SETS];
   logic [NUM_WAYS-1:0]   valid_q [NUM_SETS];
   logic [NUM_WAYS-1:0]   dirty_q [NUM_SETS];
   logic [2:0]            lru_q   [NUM_SETS];
   logic [1:0]            state_q, state_d;
   logic [WAY_W-1:0]      victim_q, victim_d, hit_way, vict, lru_way;
   logic [NUM_WAYS-1:0]   hit_vec;
   logic [INDEX_W-1:0]    idx;
   logic [TAG_W-1:0]      tag;
   logic [OFFSET_W-1:0]   off;
   logic [2:0]            lru_cur;
   logic [NB-1:0]         byte_en;
   logic [LINE_WIDTH-1:0] line_sel, bit_mask, wr_line, merged;
   logic [CORE_DATA_WIDTH-1:0] size_mask;
   logic                  misaligned, idle, look, hit_ok, miss, fill;

   assign idx  = i_addr_from_core[OFFSET_W +: INDEX_W];
   assign tag  = i_addr_from_core[ADDR_WIDTH-1 -: TAG_W];
   assign off  = i_addr_from_core[OFFSET_W-1:0];
   assign idle = state_q == S_IDLE;
   assign misaligned = (i_size == 2'd1 && i_addr_from_core[0]) ||
                       (i_size == 2'd2 && |i_addr_from_core[1:0]) ||
                       (i_size == 2'd3 && |i_addr_from_core[2:0]);
   assign look   = idle && (i_read || i_write) && !misaligned;
   assign hit_ok = look && |hit_vec;
   assign miss   = look && !(|hit_vec);
   assign fill   = state_q == S_REFILL && i_mem_read_done;

   // 4-way tree-PLRU: bit0 picks the pair, bit1/bit2 pick within pair; bits point at the LRU side
   assign lru_cur = lru_q[idx];
   assign lru_way = NUM_WAYS == 4 ? WAY_W'({lru_cur[0], lru_cur[0] ? lru_cur[2] : lru_cur[1]}) :
                    NUM_WAYS == 2 ? WAY_W'(lru_cur[0]) : '0;

   always_comb begin
      hit_vec = '0;
      hit_way = '0;
      vict    = lru_way;
      for (int w = 0; w < NUM_WAYS; w++) begin
         hit_vec[w] = valid_q[idx][w] && tag_q[w][idx] == tag;
         if (hit_vec[w]) hit_way = WAY_W'(w);
      end
      for (int w = NUM_WAYS-1; w >= 0; w--)
         if (!valid_q[idx][w]) vict = WAY_W'(w);
   end

   assign line_sel  = data_q[hit_way][idx];
   assign size_mask = ~({CORE_DATA_WIDTH{1'b1}} << (8 << i_size));
   assign byte_en   = NB'((32'd1 << (32'd1 << i_size)) - 32'd1) << off;
   assign wr_line   = LINE_WIDTH'(i_data_from_core) << {off, 3'b000};
   assign merged    = (line_sel & ~bit_mask) | (wr_line & bit_mask);

   always_comb begin
      bit_mask = '0;
      for (int b = 0; b < NB; b++) bit_mask[b*8 +: 8] = {8{byte_en[b]}};
   end

   always_comb begin
      state_d  = state_q;
      victim_d = victim_q;
      if (miss) begin
         victim_d = vict;
         state_d  = (valid_q[idx][vict] && dirty_q[idx][vict]) ? S_WB : S_REFILL;
      end else if (state_q == S_WB && i_mem_write_done) state_d = S_REFILL;
      else if (fill) state_d = S_IDLE;
   end

   assign o_stall             = miss || state_q == S_WB || state_q == S_REFILL;
   assign o_data_to_core      = (hit_ok && !i_write) ? CORE_DATA_WIDTH'(line_sel >> {off, 3'b000}) & size_mask : '0;
   assign o_load_fault        = i_read && !i_write && misaligned;
   assign o_store_fault       = i_write && misaligned;
   assign o_mem_write_valid   = state_q == S_WB;
   assign o_mem_write_address = o_mem_write_valid ? {tag_q[victim_q][idx], idx, {OFFSET_W{1'b0}}} : '0;
   assign o_mem_write_block   = o_mem_write_valid ? data_q[victim_q][idx] : '0;
   assign o_mem_read_req      = state_q == S_REFILL;
   assign o_mem_read_address  = o_mem_read_req ? {i_addr_from_core[ADDR_WIDTH-1:OFFSET_W], {OFFSET_W{1'b0}}} : '0;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q  <= S_IDLE;
         victim_q <= '0;
         for (int s = 0; s < NUM_SETS; s++) begin
            valid_q[s] <= '0;
            dirty_q[s] <= '0;
            lru_q[s]   <= '0;
         end
      end else begin
         state_q  <= state_d;
         victim_q <= victim_d;
         if (hit_ok) begin
            if (i_write) dirty_q[idx][hit_way] <= 1'b1;
            if (NUM_WAYS == 2) lru_q[idx][0] <= ~hit_way[0];
            if (NUM_WAYS == 4) begin
               lru_q[idx][0] <= ~hit_way[WAY_W-1];
               lru_q[idx][1 + int'(hit_way[WAY_W-1])] <= ~hit_way[0];
            end
         end
         if (fill) begin
            valid_q[idx][victim_q] <= 1'b1;
            dirty_q[idx][victim_q] <= 1'b0;
         end
      end
   end

   // line and tag storage carry no reset; valid bits guard them
   always_ff @(posedge i_clk) begin
      if (hit_ok && i_write) data_q[hit_way][idx] <= merged;
      if (fill) begin
         data_q[victim_q][idx] <= i_block_from_axi;
         tag_q[victim_q][idx]  <= tag;
      end
   end

`ifdef DCACHE_PERF_CNT_EN
   logic        replay_q;
   logic [31:0] hit_cnt_q, miss_cnt_q, wb_cnt_q;
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         replay_q   <= 1'b0;
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
         wb_cnt_q   <= '0;
      end else begin
         replay_q <= fill;
         if (hit_ok && !replay_q) hit_cnt_q <= hit_cnt_q + 32'd1;
         if (miss) miss_cnt_q <= miss_cnt_q + 32'd1;
         if (miss && state_d == S_WB) wb_cnt_q <= wb_cnt_q + 32'd1;
      end
   end
   assign o_hit_count  = hit_cnt_q;
   assign o_miss_count = miss_cnt_q;
   assign o_wb_count   = wb_cnt_q;
`endif
endmodule

// File: tb/tb_riscv_core_dcache_wb_nway.sv
// tb_riscv_core_dcache_wb_nway: randomized bench with a line-level cache/memory model (true LRU by timestamps).
module tb_riscv_core_dcache_wb_nway;
   logic         i_clk, i_rst_n;
   logic [63:0]  i_addr_from_core, i_data_from_core;
   logic         i_read, i_write;
   logic [1:0]   i_size;
   logic         o_stall, o_load_fault, o_store_fault, o_mem_read_req, o_mem_write_valid;
   logic [63:0]  o_data_to_core, o_mem_read_address, o_mem_write_address;
   logic         i_mem_read_done, i_mem_write_done;
   logic [255:0] i_block_from_axi, o_mem_write_block;
`ifdef DCACHE_PERF_CNT_EN
   logic [31:0]  o_hit_count, o_miss_count, o_wb_count;
`endif

   riscv_core_dcache_wb_nway dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n),
      .i_addr_from_core(i_addr_from_core), .i_data_from_core(i_data_from_core),
      .i_read(i_read), .i_write(i_write), .i_size(i_size),
      .o_stall(o_stall), .o_data_to_core(o_data_to_core),
      .o_load_fault(o_load_fault), .o_store_fault(o_store_fault),
      .o_mem_read_req(o_mem_read_req), .o_mem_read_address(o_mem_read_address),
      .i_mem_read_done(i_mem_read_done), .i_block_from_axi(i_block_from_axi),
      .o_mem_write_valid(o_mem_write_valid), .o_mem_write_address(o_mem_write_address),
      .o_mem_write_block(o_mem_write_block),
`ifdef DCACHE_PERF_CNT_EN
      .o_hit_count(o_hit_count), .o_miss_count(o_miss_count), .o_wb_count(o_wb_count),
`endif
      .i_mem_write_done(i_mem_write_done)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   int errors = 0, checks = 0;
   logic         exp_stall, exp_lf, exp_sf, exp_rr, exp_wv;
   logic [63:0]  exp_data, exp_ra, exp_wa, last_exp, cap_data;
   logic [255:0] exp_wb;
   logic [64:0]  ev [$];
   logic         prev_wv = 1'b0, prev_rr = 1'b0;

   // cache model: per set/way valid, dirty, tag, line and last-use timestamp
   bit           mv [128][2];
   bit           md [128][2];
   logic [51:0]  mtag [128][2];
   logic [255:0] mline [128][2];
   longint       stamp [128][2];
   longint       now = 0;
   logic [255:0] mem [logic [58:0]];
   int           m_hits = 0, m_miss = 0, m_wb = 0;

   task automatic chk(string nm, logic [255:0] act, logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [255:0] memline(logic [58:0] la);
      logic [63:0] x;
      if (mem.exists(la)) return mem[la];
      x = {5'b0, la};
      return {~x, x * 64'h9E3779B97F4A7C15, x ^ 64'h0123456789ABCDEF, x + 64'd7};
   endfunction

   always @(negedge i_clk) begin
      chk("stall", o_stall, exp_stall);
      chk("load_data", o_data_to_core, exp_data);
      chk("load_fault", o_load_fault, exp_lf);
      chk("store_fault", o_store_fault, exp_sf);
      chk("rd_req", o_mem_read_req, exp_rr);
      chk("rd_addr", o_mem_read_address, exp_ra);
      chk("wr_valid", o_mem_write_valid, exp_wv);
      chk("wr_addr", o_mem_write_address, exp_wa);
      chk("wr_block", o_mem_write_block, exp_wb);
`ifdef DCACHE_PERF_CNT_EN
      chk("hit_count", o_hit_count, 256'(m_hits));
      chk("miss_count", o_miss_count, 256'(m_miss));
      chk("wb_count", o_wb_count, 256'(m_wb));
`endif
      if (o_mem_write_valid && !prev_wv) ev.push_back({1'b1, o_mem_write_address});
      if (o_mem_read_req && !prev_rr) ev.push_back({1'b0, o_mem_read_address});
      prev_wv = o_mem_write_valid;
      prev_rr = o_mem_read_req;
      if (i_read && !i_write && !o_stall && !o_load_fault) cap_data = o_data_to_core;
   end

   task automatic clr_exp();
      exp_stall = 0; exp_lf = 0; exp_sf = 0; exp_rr = 0; exp_wv = 0;
      exp_data = '0; exp_ra = '0; exp_wa = '0; exp_wb = '0;
   endtask

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic model_reset();
      for (int s = 0; s < 128; s++)
         for (int w = 0; w < 2; w++) begin
            mv[s][w] = 0; md[s][w] = 0; stamp[s][w] = 0;
         end
      m_hits = 0; m_miss = 0; m_wb = 0;
   endtask

   task automatic drive(bit rd, bit wr, logic [63:0] a, logic [1:0] sz, logic [63:0] wd);
      int n, s, w, v, lat;
      bit replay;
      logic [4:0] off;
      logic [51:0] t;
      logic [255:0] ln;
      logic [63:0] val;
      n = 1 << sz;
      i_addr_from_core = a; i_data_from_core = wd; i_read = rd; i_write = wr; i_size = sz;
      i_mem_read_done = 0; i_mem_write_done = 0;
      clr_exp();
      if (!rd && !wr) begin
         i_mem_read_done = ($urandom_range(0, 7) == 0);
         i_mem_write_done = ($urandom_range(0, 7) == 0);
         step();
      end else if ((a & 64'(n - 1)) != 0) begin
         exp_lf = !wr; exp_sf = wr;
         step();
      end else begin
         s = int'(a[11:5]); t = a[63:12]; off = a[4:0];
         w = -1;
         for (int i = 0; i < 2; i++) if (mv[s][i] && mtag[s][i] == t) w = i;
         replay = (w < 0);
         if (w < 0) begin
            v = -1;
            for (int i = 1; i >= 0; i--) if (!mv[s][i]) v = i;
            if (v < 0) v = (stamp[s][0] <= stamp[s][1]) ? 0 : 1;
            exp_stall = 1;
            step();
            m_miss++;
            if (mv[s][v] && md[s][v]) begin
               m_wb++;
               lat = $urandom_range(0, 3);
               for (int c = 0; c <= lat; c++) begin
                  clr_exp(); exp_stall = 1; exp_wv = 1;
                  exp_wa = {mtag[s][v], 7'(s), 5'b0}; exp_wb = mline[s][v];
                  i_mem_read_done = ($urandom_range(0, 3) == 0);
                  i_mem_write_done = (c == lat);
                  step();
               end
               mem[{mtag[s][v], 7'(s)}] = mline[s][v];
            end
            lat = $urandom_range(0, 3);
            for (int c = 0; c <= lat; c++) begin
               clr_exp(); exp_stall = 1; exp_rr = 1; exp_ra = {a[63:5], 5'b0};
               i_mem_write_done = ($urandom_range(0, 3) == 0);
               i_mem_read_done = (c == lat);
               i_block_from_axi = (c == lat) ? memline(a[63:5]) :
                                  {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
               step();
            end
            i_mem_read_done = 0; i_mem_write_done = 0;
            mtag[s][v] = t; mv[s][v] = 1; md[s][v] = 0; mline[s][v] = memline(a[63:5]);
            w = v;
            clr_exp();
         end
         ln = mline[s][w];
         if (!wr) begin
            val = '0;
            for (int b = 0; b < n; b++) val[b*8 +: 8] = ln[(int'(off) + b)*8 +: 8];
            exp_data = val;
            last_exp = val;
         end
         step();
         if (!replay) m_hits++;
         if (wr) begin
            for (int b = 0; b < n; b++) ln[(int'(off) + b)*8 +: 8] = wd[b*8 +: 8];
            mline[s][w] = ln;
            md[s][w] = 1;
         end
         now++;
         stamp[s][w] = now;
      end
      i_read = 0; i_write = 0; i_mem_read_done = 0; i_mem_write_done = 0; i_block_from_axi = '0;
      clr_exp();
   endtask

   initial begin
      i_rst_n = 0; i_read = 0; i_write = 0; i_size = 0;
      i_addr_from_core = '0; i_data_from_core = '0;
      i_mem_read_done = 0; i_mem_write_done = 0; i_block_from_axi = '0;
      clr_exp(); model_reset(); cap_data = '0; last_exp = '0;
      mem[59'(64'h1000 >> 5)] = {192'h0011223344556677_8899AABBCCDDEEFF_0F1E2D3C4B5A6978, 64'hDEADBEEF_CAFEF00D};
      step(); step();
      i_rst_n = 1;
      step();
      // cold load then hit
      drive(1, 0, 64'h1000, 2'd3, '0);
      chk("s1_model", last_exp, 64'hDEADBEEF_CAFEF00D);
      chk("s1_replay_data", cap_data, 64'hDEADBEEF_CAFEF00D);
      cap_data = '0;
      drive(1, 0, 64'h1000, 2'd3, '0);
      chk("s1_hit_data", cap_data, 64'hDEADBEEF_CAFEF00D);
      // store byte on hit, read word back
      drive(0, 1, 64'h1003, 2'd0, 64'hAB);
      drive(1, 0, 64'h1000, 2'd2, '0);
      chk("s2_model", last_exp, 64'hABFEF00D);
      chk("s2_data", cap_data, 64'hABFEF00D);
      // same-set conflict evicts dirty 0x1000 line
      drive(1, 0, 64'h1000, 2'd3, '0);
      drive(1, 0, 64'h2000, 2'd3, '0);
      ev.delete();
      drive(1, 0, 64'h3000, 2'd3, '0);
      chk("s3_events", 256'(ev.size()), 256'd2);
      chk("s3_first_wb", ev.size() > 0 ? ev[0] : 65'd0, {1'b1, 64'h1000});
      chk("s3_then_refill", ev.size() > 1 ? ev[1] : 65'd0, {1'b0, 64'h3000});
`ifdef DCACHE_PERF_CNT_EN
      chk("s6_hits", o_hit_count, 256'd4);
      chk("s6_misses", o_miss_count, 256'd3);
      chk("s6_wbs", o_wb_count, 256'd1);
`endif
      // misaligned accesses fault with no memory traffic
      ev.delete();
      drive(1, 0, 64'h1002, 2'd2, '0);
      drive(0, 1, 64'h1001, 2'd1, 64'h55);
      chk("s4_no_axi", 256'(ev.size()), 256'd0);
      // reset in the middle of a refill
      i_addr_from_core = 64'h5000; i_read = 1; i_size = 2'd3;
      clr_exp(); exp_stall = 1;
      step();
      clr_exp(); exp_stall = 1; exp_rr = 1; exp_ra = 64'h5000;
      step(); step();
      i_rst_n = 0; i_read = 0;
      clr_exp(); model_reset();
      step(); step();
      i_rst_n = 1; i_mem_read_done = 1;
      step();
      i_mem_read_done = 0;
      ev.delete();
      drive(1, 0, 64'h5000, 2'd3, '0);
      chk("s5_remiss", ev.size() > 0 ? ev[0] : 65'd0, {1'b0, 64'h5000});
      // randomized traffic over a small conflicting address pool
      for (int k = 0; k < 400; k++) begin
         int op, n;
         logic [1:0] sz;
         logic [63:0] a;
         logic [4:0] off;
         op = $urandom_range(0, 9);
         sz = 2'($urandom_range(0, 3));
         n = 1 << sz;
         off = 5'($urandom_range(0, 31));
         if ($urandom_range(0, 7) != 0) off = off & ~5'(n - 1);
         a = (64'($urandom_range(0, 5)) << 12) | (64'($urandom_range(0, 3)) << 5) | 64'(off);
         drive(op >= 1 && op <= 4 || op == 9, op >= 5, a, sz, {$urandom(), $urandom()});
      end
      step();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
